// File: rtl/rib_sram_slave.sv
// Word-addressed SRAM responder for the RIB data port: single-cycle ack after WAIT_CYCLES wait states.
// Optional macro RIB_SRAM_SLAVE_ERR_EN adds err_o for out-of-range or misaligned accesses.
module rib_sram_slave #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
`ifdef RIB_SRAM_SLAVE_ERR_EN
    output logic        err_o,
`endif
    output logic        hold_o
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_next;
    logic          r_we;
    logic [31:0]   r_addr;
    logic [31:0]   r_data;
    logic [31:0]   r_rdata;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_commit;
    logic          w_c_we;
    logic [31:0]   w_c_addr;
    logic [31:0]   w_c_data;
    logic          w_c_inr;
    logic [AW-1:0] w_c_idx;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (req_i) begin
                    w_cnt_next = 4'(WAIT_CYCLES);
                    w_next     = (WAIT_CYCLES > 0) ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) w_next = S_ACK;
            end
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // With zero wait states the commit edge is the accept edge, so take the live inputs in IDLE.
    always_comb begin
        w_commit = rst && (w_next == S_ACK);
        w_c_we   = (r_state == S_IDLE) ? we_i   : r_we;
        w_c_addr = (r_state == S_IDLE) ? addr_i : r_addr;
        w_c_data = (r_state == S_IDLE) ? data_i : r_data;
        w_c_inr  = ((w_c_addr[31:2] >> AW) == '0);
        w_c_idx  = w_c_addr[AW+1:2];
    end

    always_ff @(posedge clk) begin
        if (w_commit && w_c_we && w_c_inr) r_mem[w_c_idx] <= w_c_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (r_state == S_IDLE && req_i) begin
                r_we   <= we_i;
                r_addr <= addr_i;
                r_data <= data_i;
            end
            if (w_commit && !w_c_we) r_rdata <= w_c_inr ? r_mem[w_c_idx] : '0;
        end
    end

`ifdef RIB_SRAM_SLAVE_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_err <= 1'b0;
        else      r_err <= w_commit && (!w_c_inr || (w_c_addr[1:0] != 2'b00));
    end

    assign err_o = r_err;
`else
    logic w_unused_lsb;
    assign w_unused_lsb = ^w_c_addr[1:0];
`endif

    assign data_o = r_rdata;
    assign ack_o  = (r_state == S_ACK);
    assign hold_o = (r_state != S_IDLE);

endmodule
